// File: rtl/alu_sequencer_pkg.sv
// Shared definitions for the ALU sequencer: opcode enum, FSM state type and
// the decoded-instruction bundle passed from seq_decode to the sequencer.
package alu_sequencer_pkg;

  localparam int unsigned INSTR_W = 9;
  localparam int unsigned OP_W    = 5;
  localparam int unsigned REG_W   = 4;
  localparam int unsigned PC_W    = 8;
  localparam int unsigned DATA_W  = 8;
  localparam int unsigned CNT_W   = 16;

  // OP_NOP doubles as the idle value of alu_op and the code for unrecognised opcodes.
  typedef enum logic [OP_W-1:0] {
    OP_NOP  = 5'd0,
    OP_ADD  = 5'd1,
    OP_SUB  = 5'd2,
    OP_SLL  = 5'd3,
    OP_SRL  = 5'd4,
    OP_BREG = 5'd5,
    OP_SUBU = 5'd6,
    OP_ADDU = 5'd7,
    OP_AND  = 5'd8,
    OP_SLRA = 5'd9,
    OP_SEQ  = 5'd10,
    OP_MOD  = 5'd11,
    OP_ADDI = 5'd12,
    OP_MV   = 5'd13,
    OP_BNE  = 5'd14,
    OP_BEZ  = 5'd15,
    OP_HALT = 5'h1F
  } op_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_DECODE,
    ST_EXEC,
    ST_WB,
    ST_HALT
  } state_e;

  typedef struct packed {
    op_e  alu_op;
    logic b_is_imm;
    logic four_shift;
    logic wr_en_class;
    logic is_branch;
    logic is_halt;
  } dec_t;

endpackage

// File: rtl/alu_sequencer_if.sv
// Fetch, ALU-control and register-file write bundle between the sequencer
// (master) and its surrounding datapath (slave).
interface alu_sequencer_if;
  import alu_sequencer_pkg::*;

  logic                start;
  logic [INSTR_W-1:0]  instr;
  logic                instr_valid;
  logic                fetch_req;
  logic [PC_W-1:0]     pc;
  op_e                 alu_op;
  logic [REG_W-1:0]    rs_addr;
  logic                b_is_imm;
  logic [DATA_W-1:0]   imm;
  logic                four_shift;
  logic [DATA_W-1:0]   alu_result;
  logic                branch_comp_pass;
  logic                wr_en;
  logic [REG_W-1:0]    wr_addr;
  logic                halted;
  logic [CNT_W-1:0]    instr_count;

  modport master (
    input  start, instr, instr_valid, alu_result, branch_comp_pass,
    output fetch_req, pc, alu_op, rs_addr, b_is_imm, imm, four_shift,
           wr_en, wr_addr, halted, instr_count
  );

  modport slave (
    output start, instr, instr_valid, alu_result, branch_comp_pass,
    input  fetch_req, pc, alu_op, rs_addr, b_is_imm, imm, four_shift,
           wr_en, wr_addr, halted, instr_count
  );

endinterface

// File: rtl/seq_decode.sv
// Combinational instruction decoder: classifies the latched instruction into
// ALU opcode, operand select, shift shortcut and writeback/branch/halt class.
module seq_decode
  import alu_sequencer_pkg::*;
(
  input  logic [INSTR_W-1:0] ir_i,
  output dec_t               dec_o
);

  logic [OP_W-1:0]  opcode;
  logic [REG_W-1:0] field;

  assign opcode = ir_i[INSTR_W-1:REG_W];
  assign field  = ir_i[REG_W-1:0];

  always_comb begin
    dec_o        = '0;
    dec_o.alu_op = OP_NOP;
    case (op_e'(opcode))
      OP_ADD, OP_SUB, OP_BREG, OP_SUBU, OP_ADDU,
      OP_AND, OP_SLRA, OP_SEQ, OP_MOD, OP_MV: begin
        dec_o.alu_op      = op_e'(opcode);
        dec_o.wr_en_class = 1'b1;
      end
      // A zero shift field selects the ALU's fixed shift-by-4 path.
      OP_SLL, OP_SRL: begin
        dec_o.alu_op      = op_e'(opcode);
        dec_o.wr_en_class = 1'b1;
        dec_o.four_shift  = (field == '0);
      end
      OP_ADDI: begin
        dec_o.alu_op      = OP_ADDI;
        dec_o.wr_en_class = 1'b1;
        dec_o.b_is_imm    = 1'b1;
      end
      OP_BNE, OP_BEZ: begin
        dec_o.alu_op    = op_e'(opcode);
        dec_o.is_branch = 1'b1;
      end
      OP_HALT: begin
        dec_o.alu_op  = OP_HALT;
        dec_o.is_halt = 1'b1;
      end
      default: begin
        dec_o.alu_op = OP_NOP;
      end
    endcase
  end

endmodule

// File: rtl/alu_sequencer.sv
// Multi-cycle instruction sequencer: fetches over a request/valid handshake,
// steers an external ALU and register file, and retires one instruction per WB.
module alu_sequencer
  import alu_sequencer_pkg::*;
(
  input  logic            CLK,
  input  logic            reset,
  alu_sequencer_if.master bus
);

  state_e              state_q, state_d;
  logic [PC_W-1:0]     pc_q, pc_d;
  logic [INSTR_W-1:0]  ir_q, ir_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                br_taken_q, br_taken_d;
  dec_t                dec;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  seq_decode u_decode (
    .ir_i  (ir_q),
    .dec_o (dec)
  );

  always_ff @(posedge CLK) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      pc_q       <= '0;
      ir_q       <= '0;
      cnt_q      <= '0;
      br_taken_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      ir_q       <= ir_d;
      cnt_q      <= cnt_d;
      br_taken_q <= br_taken_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    ir_d       = ir_q;
    cnt_d      = cnt_q;
    br_taken_d = br_taken_q;
    unique case (state_q)
      ST_IDLE: begin
        if (bus.start) state_d = ST_FETCH;
      end
      ST_FETCH: begin
        if (bus.instr_valid) begin
          ir_d    = bus.instr;
          state_d = ST_DECODE;
        end
      end
      ST_DECODE: begin
        if (dec.is_halt) begin
          state_d = ST_HALT;
          cnt_d   = sat_inc(cnt_q);
        end else begin
          state_d = ST_EXEC;
        end
      end
      // Branch condition is captured here; the target is taken from alu_result in WB.
      ST_EXEC: begin
        br_taken_d = dec.is_branch & bus.branch_comp_pass;
        state_d    = ST_WB;
      end
      ST_WB: begin
        pc_d    = br_taken_q ? bus.alu_result : pc_q + PC_W'(1);
        cnt_d   = sat_inc(cnt_q);
        state_d = ST_FETCH;
      end
      ST_HALT: begin
        state_d = ST_HALT;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Outputs are gated by reset so a WB write coinciding with reset never escapes.
  always_comb begin
    bus.fetch_req  = 1'b0;
    bus.halted     = 1'b0;
    bus.alu_op     = OP_NOP;
    bus.rs_addr    = '0;
    bus.b_is_imm   = 1'b0;
    bus.imm        = '0;
    bus.four_shift = 1'b0;
    bus.wr_en      = 1'b0;
    bus.wr_addr    = '0;
    if (!reset) begin
      bus.fetch_req = (state_q == ST_FETCH);
      bus.halted    = (state_q == ST_HALT);
      if (state_q == ST_EXEC || state_q == ST_WB) begin
        bus.alu_op     = dec.alu_op;
        bus.b_is_imm   = dec.b_is_imm;
        bus.four_shift = dec.four_shift;
        bus.rs_addr    = dec.b_is_imm ? '0 : ir_q[REG_W-1:0];
        bus.imm        = {{(DATA_W-REG_W){1'b0}}, ir_q[REG_W-1:0]};
      end
      if (state_q == ST_WB) bus.wr_en = dec.wr_en_class;
    end
  end

  assign bus.pc          = pc_q;
  assign bus.instr_count = cnt_q;

endmodule

// File: tb/tb_alu_sequencer.sv
// Scoreboard bench for alu_sequencer: directed instructions push expected
// responses; a negedge monitor follows each instruction through its cycles.
module tb_alu_sequencer;
  import alu_sequencer_pkg::*;

  logic CLK = 1'b0;
  logic reset;

  alu_sequencer_if bus ();

  alu_sequencer dut (
    .CLK   (CLK),
    .reset (reset),
    .bus   (bus)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [8:0]  instr;
    op_e         op;
    logic        bimm;
    logic [7:0]  imm;
    logic [3:0]  rs;
    logic        four;
    logic        wr;
    logic [7:0]  pc_before;
    logic [7:0]  pc_after;
    logic [15:0] cnt_after;
    int          stall;
    logic        halt;
    logic        abort;
  } exp_t;

  exp_t q[$];
  int   tests = 0;
  int   fails = 0;
  bit   done  = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
    end
  endtask

  // ---------------- monitor ----------------
  exp_t        cur;
  int          phase     = 0;
  int          stall_cnt = 0;
  bit          prev_rst  = 1'b0;
  bit          hold      = 1'b0;
  logic [7:0]  hold_pc   = '0;
  logic [15:0] hold_cnt  = '0;

  always @(negedge CLK) begin
    if (done) begin
      chk("queue_drained", 64'(q.size()), 64'd0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
    end
    if (prev_rst) begin
      chk("reset_pc", bus.pc, 0);
      chk("reset_count", bus.instr_count, 0);
    end
    if (reset) begin
      chk("reset_outputs_zero", {bus.fetch_req, bus.wr_en, bus.halted, bus.four_shift, bus.b_is_imm,
                                 bus.alu_op, bus.rs_addr, bus.imm, bus.wr_addr}, 0);
      hold = 1'b0;
    end else if (hold) begin
      chk("halt_hold", {bus.halted, bus.fetch_req, bus.pc, bus.instr_count},
                       {1'b1, 1'b0, hold_pc, hold_cnt});
    end

    case (phase)
      1: begin
        chk("decode_quiet", {bus.alu_op, bus.wr_en, bus.fetch_req}, 0);
        phase = cur.halt ? 5 : 2;
      end
      2: begin
        chk("exec_alu_op", bus.alu_op, cur.op);
        chk("exec_b_is_imm", bus.b_is_imm, cur.bimm);
        chk("exec_imm", bus.imm, cur.imm);
        chk("exec_rs_addr", bus.rs_addr, cur.rs);
        chk("exec_four_shift", bus.four_shift, cur.four);
        chk("exec_no_write", bus.wr_en, 0);
        phase = 3;
      end
      3: begin
        chk("wb_wr_en", bus.wr_en, cur.abort ? 1'b0 : cur.wr);
        if (!cur.abort) begin
          chk("wb_alu_op", bus.alu_op, cur.op);
          if (cur.wr) chk("wb_wr_addr", bus.wr_addr, 0);
        end
        phase = 4;
      end
      4: begin
        if (cur.abort) begin
          chk("abort_state", {bus.pc, bus.instr_count, bus.fetch_req, bus.halted}, 0);
        end else begin
          chk("next_pc", bus.pc, cur.pc_after);
          chk("retired_count", bus.instr_count, cur.cnt_after);
          chk("refetch", bus.fetch_req, 1);
        end
        phase = 0;
      end
      5: begin
        chk("halt_entry", {bus.halted, bus.fetch_req, bus.pc, bus.instr_count},
                          {1'b1, 1'b0, cur.pc_after, cur.cnt_after});
        hold     = 1'b1;
        hold_pc  = cur.pc_after;
        hold_cnt = cur.cnt_after;
        phase    = 0;
      end
      default: ;
    endcase

    if (phase == 0 && !reset && !hold && !bus.fetch_req)
      chk("idle_outputs", {bus.wr_en, bus.halted, bus.four_shift, bus.b_is_imm,
                           bus.alu_op, bus.rs_addr, bus.imm, bus.wr_addr}, 0);

    if (phase == 0 && !reset && q.size() > 0 && bus.fetch_req) begin
      if (bus.instr_valid) begin
        cur = q.pop_front();
        chk("fetch_stall_cycles", 64'(stall_cnt), 64'(cur.stall));
        chk("fetch_pc", bus.pc, cur.pc_before);
        stall_cnt = 0;
        phase     = 1;
      end else begin
        stall_cnt++;
        chk("stall_pc", bus.pc, q[0].pc_before);
      end
    end
    prev_rst = reset;
  end

  // ---------------- stimulus ----------------
  task automatic wait_fetch();
    int n = 0;
    while (!bus.fetch_req) begin
      @(posedge CLK); #1;
      n++;
      if (n > 40) begin
        $display("FAIL fetch_timeout: fetch_req stayed 0, required 1");
        $fatal(1, "fetch_req never asserted");
      end
    end
  endtask

  task automatic issue(input logic [8:0] ins, input int stall, input logic [7:0] res, input logic bcp,
                       input op_e op, input logic bimm, input logic [7:0] imm, input logic [3:0] rs,
                       input logic four, input logic wr, input logic [7:0] pcb, input logic [7:0] pca,
                       input logic [15:0] cnta, input logic halt, input logic abort);
    exp_t e;
    e.instr = ins;  e.op = op;     e.bimm = bimm; e.imm = imm;   e.rs = rs;
    e.four = four;  e.wr = wr;     e.pc_before = pcb; e.pc_after = pca;
    e.cnt_after = cnta; e.stall = stall; e.halt = halt; e.abort = abort;
    q.push_back(e);
    wait_fetch();
    bus.alu_result       = res;
    bus.branch_comp_pass = bcp;
    repeat (stall) begin
      @(posedge CLK); #1;
    end
    bus.instr       = ins;
    bus.instr_valid = 1'b1;
    @(posedge CLK); #1;
    bus.instr_valid = 1'b0;
  endtask

  task automatic pulse_start();
    @(posedge CLK); #1;
    bus.start = 1'b1;
    @(posedge CLK); #1;
    bus.start = 1'b0;
  endtask

  initial begin
    reset                = 1'b1;
    bus.start            = 1'b0;
    bus.instr            = '0;
    bus.instr_valid      = 1'b0;
    bus.alu_result       = '0;
    bus.branch_comp_pass = 1'b0;
    repeat (3) @(posedge CLK);
    #1 reset = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    pulse_start();
    //     instr   stall res    bcp op       bimm imm    rs    four wr  pcb    pca    cnt    halt abort
    issue(9'h0C3, 0, 8'h99, 0, OP_ADDI, 1, 8'h03, 4'h0, 0, 1, 8'h00, 8'h01, 16'd1, 0, 0);
    issue(9'h0E5, 0, 8'h20, 1, OP_BNE,  0, 8'h05, 4'h5, 0, 0, 8'h01, 8'h20, 16'd2, 0, 0);
    issue(9'h0E5, 0, 8'h40, 0, OP_BNE,  0, 8'h05, 4'h5, 0, 0, 8'h20, 8'h21, 16'd3, 0, 0);
    issue(9'h030, 5, 8'h00, 0, OP_SLL,  0, 8'h00, 4'h0, 1, 1, 8'h21, 8'h22, 16'd4, 0, 0);
    issue(9'h032, 0, 8'h00, 0, OP_SLL,  0, 8'h02, 4'h2, 0, 1, 8'h22, 8'h23, 16'd5, 0, 0);
    issue(9'h040, 2, 8'h77, 1, OP_SRL,  0, 8'h00, 4'h0, 1, 1, 8'h23, 8'h24, 16'd6, 0, 0);
    issue(9'h109, 0, 8'h66, 1, OP_NOP,  0, 8'h09, 4'h9, 0, 0, 8'h24, 8'h25, 16'd7, 0, 0);
    issue(9'h0F0, 0, 8'hFF, 1, OP_BEZ,  0, 8'h00, 4'h0, 0, 0, 8'h25, 8'hFF, 16'd8, 0, 0);
    issue(9'h017, 0, 8'h55, 1, OP_ADD,  0, 8'h07, 4'h7, 0, 1, 8'hFF, 8'h00, 16'd9, 0, 0);
    // ADD interrupted by reset while in WB
    issue(9'h014, 0, 8'h11, 0, OP_ADD,  0, 8'h04, 4'h4, 0, 0, 8'h00, 8'h00, 16'd0, 0, 1);
    repeat (2) begin
      @(posedge CLK); #1;
    end
    reset = 1'b1;
    repeat (2) begin
      @(posedge CLK); #1;
    end
    reset = 1'b0;
    repeat (2) begin
      @(posedge CLK); #1;
    end
    pulse_start();
    issue(9'h0D1, 0, 8'h00, 0, OP_MV,   0, 8'h01, 4'h1, 0, 1, 8'h00, 8'h01, 16'd1, 0, 0);
    issue(9'h1F0, 1, 8'h00, 0, OP_HALT, 0, 8'h00, 4'h0, 0, 0, 8'h01, 8'h01, 16'd2, 1, 0);
    repeat (3) begin
      @(posedge CLK); #1;
    end
    bus.start       = 1'b1;
    bus.instr       = 9'h0C3;
    bus.instr_valid = 1'b1;
    repeat (3) begin
      @(posedge CLK); #1;
    end
    bus.start       = 1'b0;
    bus.instr_valid = 1'b0;
    repeat (4) begin
      @(posedge CLK); #1;
    end
    done = 1'b1;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation still running at %0t, required completion", $time);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/alu_sequencer.md
ALU_SEQUENCER -- requirements
Module: alu_sequencer

Interface
REQ-001 SHALL have port CLK  input  1  single clock, all state updates on rising edge.
REQ-002 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-003 SHALL have port start  input  1  one-cycle pulse, leaves IDLE and begins fetching at current pc.
REQ-004 SHALL have port instr  input  9  fetched instruction: [8:4] opcode, [3:0] register index / immediate.
REQ-005 SHALL have port instr_valid  input  1  instr is valid this cycle (fetch handshake).
REQ-006 SHALL have port fetch_req  output  1  fetch request, held until instr_valid.
REQ-007 SHALL have port pc  output  8  current instruction address.
REQ-008 SHALL have port alu_op  output  5  ALU opcode from the shared op enum.
REQ-009 SHALL have port rs_addr  output  4  register-file read address for ALU second operand.
REQ-010 SHALL have port b_is_imm  output  1  select zero-extended imm, not rs data, as ALU second operand.
REQ-011 SHALL have port imm  output  8  {4'b0, instr[3:0]} of the latched instruction.
REQ-012 SHALL have port four_shift  output  1  shift-by-4 shortcut flag to ALU.
REQ-013 SHALL have port alu_result  input  8  ALU result.
REQ-014 SHALL have port branch_comp_pass  input  1  ALU branch-condition flag.
REQ-015 SHALL have port wr_en  output  1  register-file write strobe, one cycle.
REQ-016 SHALL have port wr_addr  output  4  register-file write address.
REQ-017 SHALL have port halted  output  1  HALT opcode retired.
REQ-018 SHALL have port instr_count  output  16  retired-instruction counter.

Function
REQ-019 SHALL implement FSM states IDLE, FETCH, DECODE, EXEC, WB, HALT; IDLE->FETCH on start; FETCH->DECODE on instr_valid (instr latched into IR); DECODE->EXEC; EXEC->WB; WB->FETCH; DECODE->HALT on HALT opcode (5'b11111).
REQ-020 SHALL assert fetch_req only in FETCH; stay in FETCH while instr_valid=0; instr_valid outside FETCH ignored.
REQ-021 SHALL drive alu_op, rs_addr, b_is_imm, imm, four_shift from IR in EXEC and WB, and alu_op=0 elsewhere.
REQ-022 SHALL set b_is_imm=1 only for ADDI; rs_addr=IR[3:0] otherwise.
REQ-023 SHALL set four_shift=1 only for SLL/SRL with IR[3:0]==4'h0.
REQ-024 SHALL in WB assert wr_en with wr_addr=4'h0 for ADD, SUB, SLL, SRL, BREG, SUBU, ADDU, AND, SLRA, SEQ, MOD, ADDI, MV; wr_en=0 for BNE, BEZ, HALT, unrecognised opcodes.
REQ-025 SHALL in WB update pc to alu_result for BNE/BEZ when branch_comp_pass=1 (sampled in EXEC), else pc+1 modulo 256 (0xFF wraps to 0x00).
REQ-026 SHALL treat unrecognised opcodes as NOP: full FETCH..WB sequence, no write, pc+1.
REQ-027 SHALL increment instr_count by 1 in every WB and on HALT entry, saturating at 16'hFFFF.
REQ-028 SHALL remain in HALT (halted=1, pc frozen, fetch_req=0) until reset; start ignored in HALT and in any non-IDLE state.
REQ-029 SHALL give latency of exactly 4 cycles per instruction when instr_valid is returned in the first FETCH cycle.

Reset
REQ-030 SHALL on reset=1 at a rising edge, from any state including mid-instruction, enter IDLE with pc=0, IR=0, instr_count=0.
REQ-031 SHALL hold fetch_req, wr_en, halted, four_shift, b_is_imm=0, alu_op=0, rs_addr=0, imm=0, wr_addr=0 during and after reset until start.
REQ-032 SHALL suppress any pending WB write when reset coincides with WB.

Structure
REQ-033 SHALL take the op enum (incl. new HALT=5'b11111) and the FSM state typedef from the shared definitions package.
REQ-034 SHALL contain one sub-module, seq_decode, purely combinational, mapping IR to alu_op/b_is_imm/four_shift/wr_en_class/is_branch/is_halt.

Verification
REQ-035 SHALL cover: reset, start, instr=ADDI,imm 3 with instr_valid in first FETCH -> alu_op=ADDI, b_is_imm=1, imm=8'h03, wr_en pulse with wr_addr=0 in cycle 4, pc 0->1, instr_count=1.
REQ-036 SHALL cover: BNE with branch_comp_pass=1, alu_result=8'h20 -> pc=8'h20 after WB, wr_en=0; repeat with branch_comp_pass=0 -> pc+1.
REQ-037 SHALL cover: instr_valid withheld 5 cycles -> fetch_req held 5 cycles, pc stable, no DECODE entry.
REQ-038 SHALL cover: SLL with IR[3:0]=0 -> four_shift=1; SLL with IR[3:0]=2 -> four_shift=0, rs_addr=2.
REQ-039 SHALL cover: pc=8'hFF non-branch -> pc=8'h00; HALT -> halted=1, later start and instr_valid ignored.
REQ-040 SHALL cover: reset asserted in WB of an ADD -> no wr_en, state IDLE, pc=0, instr_count=0.
